// File: rtl/fir_mc_serial.sv
// Multi-channel time-multiplexed FIR: one signed MAC iterated over TAPS
// cycles per sample, per-channel circular history, loadable coefficients.
module fir_mc_serial #(
  parameter int DATAW = 16,
  parameter int COEFW = 16,
  parameter int TAPS = 8,
  parameter int CHANNELS = 2,
  parameter int SHIFT = 15,
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1,
  localparam int ACCW = DATAW + COEFW + $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHW-1:0]   in_channel,
  input  logic [DATAW-1:0] in_sample,
  input  logic             coef_wr_en,
  output logic             coef_wr_ready,
  input  logic [TW-1:0]    coef_wr_addr,
  input  logic [COEFW-1:0] coef_wr_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHW-1:0]   out_channel,
  output logic [DATAW-1:0] out_sample,
  output logic             out_sat
);

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_e;

  localparam int PW = DATAW + COEFW;
  localparam logic [TW:0] TAPS_W = (TW+1)'(TAPS);
  localparam logic [CHW:0] CHAN_W = (CHW+1)'(CHANNELS);
  localparam logic [TW-1:0] K_LAST = TW'(TAPS - 1);
  localparam logic signed [ACCW:0] RND =
    (SHIFT > 0) ? ((ACCW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [ACCW:0] MAXV =
    {{(ACCW+2-DATAW){1'b0}}, {(DATAW-1){1'b1}}};
  localparam logic signed [ACCW:0] MINV =
    {{(ACCW+2-DATAW){1'b1}}, {(DATAW-1){1'b0}}};

  state_e state_q, state_d;
  logic signed [COEFW-1:0] coef_q [TAPS];
  logic signed [COEFW-1:0] coef_d [TAPS];
  logic signed [DATAW-1:0] hist_q [CHANNELS][TAPS];
  logic signed [DATAW-1:0] hist_d [CHANNELS][TAPS];
  logic [TW-1:0] wptr_q [CHANNELS];
  logic [TW-1:0] wptr_d [CHANNELS];
  logic [TW-1:0] rptr_q, rptr_d;
  logic [TW-1:0] k_q, k_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic out_valid_q, out_valid_d;
  logic out_sat_q, out_sat_d;
  logic [CHW-1:0] out_channel_q, out_channel_d;
  logic signed [DATAW-1:0] out_sample_q, out_sample_d;

  logic idle;
  logic ch_ok;
  logic addr_ok;
  logic signed [DATAW-1:0] x_mul;
  logic signed [COEFW-1:0] c_mul;
  logic signed [PW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW:0] rnd;
  logic signed [ACCW:0] shd;
  logic signed [DATAW-1:0] sat_val;
  logic sat_hit;

  assign idle = (state_q == IDLE);
  assign ch_ok = {1'b0, in_channel} < CHAN_W;
  assign addr_ok = {1'b0, coef_wr_addr} < TAPS_W;

  assign in_ready = idle & ~coef_wr_en;
  assign coef_wr_ready = idle;

  assign out_valid = out_valid_q;
  assign out_sat = out_sat_q;
  assign out_channel = out_channel_q;
  assign out_sample = out_sample_q;

  // rptr walks backwards from the newest sample as k advances
  assign x_mul = hist_q[ch_q][rptr_q];
  assign c_mul = coef_q[k_q];
  assign prod = {{COEFW{x_mul[DATAW-1]}}, x_mul}
              * {{DATAW{c_mul[COEFW-1]}}, c_mul};
  assign prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};

  assign rnd = {acc_q[ACCW-1], acc_q} + RND;
  assign shd = rnd >>> SHIFT;

  always_comb begin
    sat_hit = 1'b0;
    sat_val = shd[DATAW-1:0];
    if (shd > MAXV) begin
      sat_hit = 1'b1;
      sat_val = MAXV[DATAW-1:0];
    end else if (shd < MINV) begin
      sat_hit = 1'b1;
      sat_val = MINV[DATAW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    coef_d = coef_q;
    hist_d = hist_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    k_d = k_q;
    ch_d = ch_q;
    acc_d = acc_q;
    out_valid_d = out_valid_q;
    out_sat_d = out_sat_q;
    out_channel_d = out_channel_q;
    out_sample_d = out_sample_q;
    unique case (state_q)
      IDLE: begin
        if (coef_wr_en) begin
          if (addr_ok) coef_d[coef_wr_addr] = coef_wr_data;
        end else if (in_valid && ch_ok) begin
          hist_d[in_channel][wptr_q[in_channel]] = in_sample;
          wptr_d[in_channel] = (wptr_q[in_channel] == K_LAST) ?
            '0 : wptr_q[in_channel] + TW'(1);
          rptr_d = wptr_q[in_channel];
          ch_d = in_channel;
          acc_d = '0;
          k_d = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + prod_ext;
        rptr_d = (rptr_q == '0) ? K_LAST : rptr_q - TW'(1);
        k_d = k_q + TW'(1);
        if (k_q == K_LAST) state_d = ROUND;
      end
      ROUND: begin
        out_sample_d = sat_val;
        out_sat_d = sat_hit;
        out_channel_d = ch_q;
        out_valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      coef_q <= '{default: '0};
      hist_q <= '{default: '0};
      wptr_q <= '{default: '0};
      rptr_q <= '0;
      k_q <= '0;
      ch_q <= '0;
      acc_q <= '0;
      out_valid_q <= 1'b0;
      out_sat_q <= 1'b0;
      out_channel_q <= '0;
      out_sample_q <= '0;
    end else begin
      state_q <= state_d;
      coef_q <= coef_d;
      hist_q <= hist_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      k_q <= k_d;
      ch_q <= ch_d;
      acc_q <= acc_d;
      out_valid_q <= out_valid_d;
      out_sat_q <= out_sat_d;
      out_channel_q <= out_channel_d;
      out_sample_q <= out_sample_d;
    end
  end

endmodule

// File: tb/tb_fir_mc_serial.sv
// Directed bench for fir_mc_serial: u0 has SHIFT=0 (filtering, saturation,
// handshakes, reset), u1 has SHIFT=15 (rounding).
module tb_fir_mc_serial;

  localparam int T = 4;

  typedef struct {
    int inst;
    int cs;
    int ch;
    int smp;
    int y;
    int sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] in_valid, in_ready, coef_wr_en, coef_wr_ready;
  logic [1:0] out_valid, out_ready, out_sat;
  logic [1:0][1:0] in_channel, out_channel, coef_wr_addr;
  logic [1:0][15:0] in_sample, coef_wr_data, out_sample;

  int n_vec = 0;
  int n_err = 0;
  int cset [5][4] = '{
    '{1, 2, 3, 4},
    '{1, 1, 1, 1},
    '{32767, 32767, 32767, 32767},
    '{1, 0, 0, 0},
    '{16384, 0, 0, 0}
  };
  int cur_cs [2];
  vec_t tv [$];

  always #5 clk = ~clk;

  fir_mc_serial #(
    .DATAW(16), .COEFW(16), .TAPS(T), .CHANNELS(3), .SHIFT(0)
  ) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_channel(in_channel[0]), .in_sample(in_sample[0]),
    .coef_wr_en(coef_wr_en[0]), .coef_wr_ready(coef_wr_ready[0]),
    .coef_wr_addr(coef_wr_addr[0]), .coef_wr_data(coef_wr_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_channel(out_channel[0]), .out_sample(out_sample[0]),
    .out_sat(out_sat[0])
  );

  fir_mc_serial #(
    .DATAW(16), .COEFW(16), .TAPS(T), .CHANNELS(3), .SHIFT(15)
  ) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_channel(in_channel[1]), .in_sample(in_sample[1]),
    .coef_wr_en(coef_wr_en[1]), .coef_wr_ready(coef_wr_ready[1]),
    .coef_wr_addr(coef_wr_addr[1]), .coef_wr_data(coef_wr_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_channel(out_channel[1]), .out_sample(out_sample[1]),
    .out_sat(out_sat[1])
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_coefs(input int i, input int cs);
    for (int t = 0; t < T; t++) begin
      @(negedge clk);
      coef_wr_en[i] = 1'b1;
      coef_wr_addr[i] = 2'(t);
      coef_wr_data[i] = 16'(cset[cs][t]);
      #1 chk($sformatf("coef_wr_ready_u%0d", i), coef_wr_ready[i], 1);
    end
    @(negedge clk);
    coef_wr_en[i] = 1'b0;
    cur_cs[i] = cs;
  endtask

  task automatic send(input int i, input int ch, input int smp,
                      input int y, input int sat, input string nm);
    int c;
    int lat;
    @(negedge clk);
    in_valid[i] = 1'b1;
    in_channel[i] = 2'(ch);
    in_sample[i] = 16'(smp);
    out_ready[i] = 1'b1;
    c = 0;
    while (!in_ready[i] && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!in_ready[i]) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_accept: got in_ready=0, expected 1", nm);
    end
    @(posedge clk);
    #1 in_valid[i] = 1'b0;
    lat = 0;
    c = 0;
    while (lat == 0 && c < T + 6) begin
      @(negedge clk);
      c++;
      if (out_valid[i]) lat = c;
    end
    chk({nm, "_latency"}, lat, T + 2);
    if (lat != 0) begin
      chk({nm, "_sample"}, $signed(out_sample[i]), y);
      chk({nm, "_sat"}, out_sat[i], sat);
      chk({nm, "_channel"}, out_channel[i], ch);
      @(negedge clk);
      chk({nm, "_valid_drop"}, out_valid[i], 0);
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    if (cur_cs[v.inst] != v.cs) load_coefs(v.inst, v.cs);
    send(v.inst, v.ch, v.smp, v.y, v.sat, $sformatf("vec%0d", idx));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int bad_v, bad_s, bad_ir, bad_cr;

    tv.push_back('{0, 0, 0, 1, 1, 0});
    tv.push_back('{0, 0, 0, 0, 2, 0});
    tv.push_back('{0, 0, 0, 0, 3, 0});
    tv.push_back('{0, 0, 0, 0, 4, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0});
    tv.push_back('{0, 1, 0, 1, 1, 0});
    tv.push_back('{0, 1, 1, 10, 10, 0});
    tv.push_back('{0, 1, 0, 0, 1, 0});
    tv.push_back('{0, 1, 1, 10, 20, 0});
    tv.push_back('{0, 1, 0, 0, 1, 0});
    tv.push_back('{0, 1, 1, 10, 30, 0});
    tv.push_back('{0, 2, 0, 32767, 32767, 1});
    tv.push_back('{0, 2, 0, 32767, 32767, 1});
    tv.push_back('{0, 2, 0, 32767, 32767, 1});
    tv.push_back('{0, 2, 0, 32767, 32767, 1});
    tv.push_back('{0, 2, 0, -32767, 32767, 1});
    tv.push_back('{0, 2, 0, -32767, 0, 0});
    tv.push_back('{0, 2, 0, -32767, -32768, 1});
    tv.push_back('{0, 2, 0, -32767, -32768, 1});
    tv.push_back('{0, 3, 0, 32767, 32767, 0});
    tv.push_back('{0, 3, 0, -32768, -32768, 0});
    tv.push_back('{0, 3, 1, -5, -5, 0});
    tv.push_back('{1, 4, 0, 3, 2, 0});
    tv.push_back('{1, 4, 0, -3, -1, 0});
    tv.push_back('{1, 4, 0, 1, 1, 0});
    tv.push_back('{1, 4, 0, -1, 0, 0});

    cur_cs = '{-1, -1};
    rst = 1'b0;
    in_valid = '0;
    in_channel = '0;
    in_sample = '0;
    coef_wr_en = '0;
    coef_wr_addr = '0;
    coef_wr_data = '0;
    out_ready = '1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_out_valid_u%0d", i), out_valid[i], 0);
      chk($sformatf("rst_out_sample_u%0d", i), out_sample[i], 0);
      chk($sformatf("rst_out_channel_u%0d", i), out_channel[i], 0);
      chk($sformatf("rst_out_sat_u%0d", i), out_sat[i], 0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rel_in_ready_u%0d", i), in_ready[i], 1);
      chk($sformatf("rel_coef_ready_u%0d", i), coef_wr_ready[i], 1);
    end

    foreach (tv[j]) apply_vec(tv[j], j);

    // out-of-range channel is swallowed without starting a computation
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_channel[0] = 2'd3;
    in_sample[0] = 16'd100;
    #1 chk("disc_in_ready", in_ready[0], 1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("disc_idle", in_ready[0], 1);
    seen = 0;
    repeat (T + 4) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    chk("disc_no_out", seen, 0);

    @(negedge clk);
    in_valid[0] = 1'b1;
    in_channel[0] = 2'd0;
    in_sample[0] = 16'd55;
    coef_wr_en[0] = 1'b1;
    coef_wr_addr[0] = 2'd1;
    coef_wr_data[0] = 16'd0;
    #1 chk("prio_in_ready", in_ready[0], 0);
    chk("prio_coef_ready", coef_wr_ready[0], 1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    coef_wr_en[0] = 1'b0;
    seen = 0;
    repeat (T + 4) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    chk("prio_no_out", seen, 0);

    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1;
    in_channel[0] = 2'd1;
    in_sample[0] = 16'd123;
    #1 chk("bp_accept", in_ready[0], 1);
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    seen = 0;
    while (!out_valid[0] && seen < T + 6) begin
      @(negedge clk);
      seen++;
    end
    chk("bp_latency", seen, T + 2);
    bad_v = 0;
    bad_s = 0;
    bad_ir = 0;
    bad_cr = 0;
    repeat (10) begin
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_channel[0] = 2'd0;
      in_sample[0] = 16'd77;
      coef_wr_en[0] = 1'b1;
      coef_wr_addr[0] = 2'd0;
      coef_wr_data[0] = 16'd999;
      #1;
      if (out_valid[0] !== 1'b1) bad_v++;
      if (out_sample[0] !== 16'd123) bad_s++;
      if (in_ready[0] !== 1'b0) bad_ir++;
      if (coef_wr_ready[0] !== 1'b0) bad_cr++;
    end
    chk("bp_valid_held", bad_v, 0);
    chk("bp_sample_stable", bad_s, 0);
    chk("bp_in_ready_low", bad_ir, 0);
    chk("bp_coef_ready_low", bad_cr, 0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    coef_wr_en[0] = 1'b0;
    out_ready[0] = 1'b1;
    seen = 0;
    repeat (T + 4) begin
      if (out_valid[0]) seen++;
      @(negedge clk);
    end
    chk("bp_one_result", seen, 1);
    send(0, 1, 7, 7, 0, "bp_coef_kept");

    // abort while the MAC is at k=2
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_channel[0] = 2'd0;
    in_sample[0] = 16'd9;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", in_ready[0], 0);
    rst = 1'b0;
    #1 chk("mid_rst_valid", out_valid[0], 0);
    chk("mid_rst_idle", in_ready[0], 1);
    @(negedge clk);
    rst = 1'b1;
    cur_cs = '{-1, -1};
    seen = 0;
    repeat (T + 4) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    chk("mid_rst_no_out", seen, 0);
    send(0, 0, 5, 0, 0, "rst_coef0");
    apply_vec('{0, 0, 0, 0, 10, 0}, 100);
    apply_vec('{0, 0, 0, 0, 15, 0}, 101);
    apply_vec('{0, 0, 0, 0, 20, 0}, 102);
    apply_vec('{0, 0, 0, 0, 0, 0}, 103);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
